// File: rtl/dff_bist_checker.sv
// Built-in stimulus/response checker for a single flip-flop DUT: launches LFSR bits on dut_d,
// compares dut_q/dut_qn against a delayed copy and reports a saturating mismatch count.
module dff_bist_checker #(
   parameter int         N_VECTORS = 16,
   parameter int         LATENCY   = 1,
   parameter logic [7:0] SEED      = 8'hA5,
   parameter int         ERR_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             dut_d,
   input  logic             dut_q,
   input  logic             dut_qn,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count
);

   // An all-zero seed would lock the LFSR up.
   localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [7:0] LAST     = 8'(N_VECTORS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state, state_nxt;
   logic [7:0]       lfsr, cnt;
   logic [LATENCY:0] exp_pipe, vld_pipe;
   logic             first, launch, launch_bit, mismatch, cmp_last;
   logic [ERR_W-1:0] err_nxt;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   assign first      = (state == IDLE || state == DONE) && start;
   assign launch     = first || (state == RUN);
   assign launch_bit = first ? SEED_EFF[7] : lfsr[7];
   assign mismatch   = (dut_q != exp_pipe[LATENCY]) | (dut_qn != ~exp_pipe[LATENCY]);
   // Last compare of a run: oldest stage valid, nothing younger behind it.
   assign cmp_last   = vld_pipe[LATENCY] && (vld_pipe[LATENCY-1:0] == '0);

   assign busy = (state == RUN) || (state == DRAIN);
   assign done = (state == DONE);

   always_comb begin
      err_nxt = err_count;
      if (first)
         err_nxt = '0;
      else if (vld_pipe[LATENCY] && mismatch && err_count != '1)
         err_nxt = err_count + 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = (N_VECTORS == 1) ? DRAIN : RUN;
         RUN:        if (cnt == LAST) state_nxt = DRAIN;
         DRAIN:      if (cmp_last) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr      <= SEED_EFF;
         cnt       <= 8'd0;
         dut_d     <= 1'b0;
         exp_pipe  <= '0;
         vld_pipe  <= '0;
         err_count <= '0;
         pass      <= 1'b0;
      end else begin
         err_count <= err_nxt;
         exp_pipe  <= {exp_pipe[LATENCY-1:0], launch_bit};
         vld_pipe  <= {vld_pipe[LATENCY-1:0], launch};
         if (first) begin
            lfsr  <= lfsr_step(SEED_EFF);
            dut_d <= SEED_EFF[7];
            cnt   <= 8'd1;
            pass  <= 1'b0;
         end else if (state == RUN) begin
            lfsr  <= lfsr_step(lfsr);
            dut_d <= lfsr[7];
            cnt   <= cnt + 8'd1;
         end
         if (state == DRAIN && cmp_last)
            pass <= (err_nxt == '0);
      end
   end

endmodule

// File: tb/tb_dff_bist_checker.sv
// Bench for dff_bist_checker: a behavioural DFF beside each checker instance, faults injected
// on the DUT outputs, expected run results queued at start and checked when done rises.
module tb_dff_bist_checker;

   logic       clk = 1'b0, rst_n = 1'b0, start1 = 1'b0, start2 = 1'b0;
   logic       d1, d2, dq1, dqn1, dq2, dqn2;
   logic       busy1, done1, pass1, busy2, done2, pass2;
   logic [7:0] err1, err2;
   logic       q1, q2a, q2b;
   int         fmode = 0;      // 0 ideal, 1 q stuck 0, 2 qn tied to q
   bit         two_stage = 1'b1;

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      q1  <= d1;
      q2a <= d2;
      q2b <= q2a;
   end

   assign dq1  = (fmode == 1) ? 1'b0 : q1;
   assign dqn1 = (fmode == 1) ? 1'b1 : (fmode == 2) ? q1 : ~q1;
   assign dq2  = two_stage ? q2b : q2a;
   assign dqn2 = ~dq2;

   dff_bist_checker u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .dut_d(d1), .dut_q(dq1), .dut_qn(dqn1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1));

   dff_bist_checker #(.LATENCY(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .dut_d(d2), .dut_q(dq2), .dut_qn(dqn2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2));

   typedef struct {int cyc; int err; int pass;} exp_t;
   exp_t sb[$];
   int   total = 0, bad = 0;
   bit   bits[16];

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic gen_bits();
      logic [7:0] l;
      l = 8'hA5;
      for (int i = 0; i < 16; i++) begin
         bits[i] = l[7];
         l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
   endtask

   // One run: queue the expectation, start, follow dut_d against the reference
   // sequence and count edges until done rises.
   task automatic run_one(input string tag, input int inst, input bit hold,
                          input int exp_err, input int exp_cyc, input bit repulse);
      exp_t e;
      int   n;
      e.cyc = exp_cyc; e.err = exp_err; e.pass = (exp_err == 0) ? 1 : 0;
      sb.push_back(e);
      @(negedge clk);
      if (inst == 1) start1 = 1'b1; else start2 = 1'b1;
      @(posedge clk); #1;
      if (!hold) begin start1 = 1'b0; start2 = 1'b0; end
      n = 0;
      while (n < 60) begin
         if (n < 16) chk({tag, "_dut_d"}, int'(inst == 1 ? d1 : d2), int'(bits[n]));
         if (repulse && n == 3) start1 = 1'b1;
         if (repulse && n == 5) start1 = 1'b0;
         if (inst == 1 ? done1 : done2) break;
         @(posedge clk); #1;
         n++;
      end
      e = sb.pop_front();
      chk({tag, "_cycles"}, n, e.cyc);
      chk({tag, "_err"}, int'(inst == 1 ? err1 : err2), e.err);
      chk({tag, "_pass"}, int'(inst == 1 ? pass1 : pass2), e.pass);
   endtask

   initial begin
      int ones, e1;
      gen_bits();
      #12;
      chk("rst_busy", int'(busy1), 0);
      chk("rst_done", int'(done1), 0);
      chk("rst_pass", int'(pass1), 0);
      chk("rst_err", int'(err1), 0);
      chk("rst_dut_d", int'(d1), 0);
      chk("seq_b0", int'(bits[0]), 1);
      chk("seq_b1", int'(bits[1]), 0);
      @(negedge clk); rst_n = 1'b1;

      fmode = 0;
      run_one("ideal", 1, 1'b0, 0, 17, 1'b0);

      fmode = 1;
      ones = 0;
      for (int i = 0; i < 16; i++) ones += int'(bits[i]);
      run_one("stuck0", 1, 1'b0, ones, 17, 1'b0);

      fmode = 2;
      run_one("qn_eq_q", 1, 1'b0, 16, 17, 1'b0);

      // Abort a faulty run mid-way; nothing of it may survive.
      fmode = 1;
      @(negedge clk); start1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("mid_busy", int'(busy1), 1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy1), 0);
      chk("abort_done", int'(done1), 0);
      chk("abort_pass", int'(pass1), 0);
      chk("abort_err", int'(err1), 0);
      chk("abort_dut_d", int'(d1), 0);
      @(negedge clk); rst_n = 1'b1;
      fmode = 0;
      run_one("after_rst", 1, 1'b0, 0, 17, 1'b0);

      run_one("repulse", 1, 1'b0, 0, 17, 1'b1);
      run_one("b2b_a", 1, 1'b1, 0, 17, 1'b0);
      run_one("b2b_b", 1, 1'b0, 0, 17, 1'b0);

      two_stage = 1'b1;
      run_one("lat2", 2, 1'b0, 0, 18, 1'b0);
      // 1-stage DUT seen by a 2-edge checker: vector k meets bit k+1 (last one held).
      two_stage = 1'b0;
      e1 = 0;
      for (int k = 0; k < 16; k++) if (bits[k] != bits[(k < 15) ? k + 1 : 15]) e1++;
      run_one("lat2_1stage", 2, 1'b0, e1, 18, 1'b0);
      chk("lat2_1stage_fails", int'(pass2), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
